// File: rtl/wakeup_issue_queue_pkg.sv
// Shared types for the wakeup issue queue: ALU opcodes, tag width and the queue entry record.
// Included by the selector and the top-level queue.
package wakeup_issue_queue_pkg;

    localparam int AL_FUNC      = 4;
    localparam int REG_ADDR_LEN = 6;

    typedef enum logic [AL_FUNC-1:0] {
        ALU_NOP = 4'd0,
        ALU_ADD = 4'd1,
        ALU_SUB = 4'd2,
        ALU_AND = 4'd3,
        ALU_OR  = 4'd4,
        ALU_XOR = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7,
        ALU_SRA = 4'd8
    } alu_op_e;

    typedef struct packed {
        logic                    valid;
        logic [AL_FUNC-1:0]      insn;
        logic [REG_ADDR_LEN-1:0] inp1;
        logic                    rdy1;
        logic [REG_ADDR_LEN-1:0] inp2;
        logic                    rdy2;
        logic [REG_ADDR_LEN-1:0] dst;
    } iq_entry_t;

    // Applies a CDB broadcast to one stored entry; invalid entries are never woken.
    function automatic iq_entry_t iq_wakeup(
        input iq_entry_t               e,
        input logic                    cdb_valid,
        input logic [REG_ADDR_LEN-1:0] cdb_tag
    );
        iq_entry_t r;
        r      = e;
        r.rdy1 = e.rdy1 | (cdb_valid & e.valid & (e.inp1 == cdb_tag));
        r.rdy2 = e.rdy2 | (cdb_valid & e.valid & (e.inp2 == cdb_tag));
        return r;
    endfunction

endpackage

// File: rtl/wakeup_issue_queue_select.sv
// Oldest-ready selector: turns a per-slot request vector into a one-hot grant,
// its index and an any-grant flag. Slot 0 is oldest, so the lowest index wins.
module iq_oldest_ready_select #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         any
);

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && !any) begin
                grant[i] = 1'b1;
                idx      = W'(i);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wakeup_issue_queue.sv
// Collapsing out-of-order ALU issue queue with CDB wakeup and oldest-ready select.
// Optional macro IQ_LOAD_BYPASS_EN folds a same-cycle CDB broadcast into the ready bits of a dispatched op.
module wakeup_issue_queue
    import wakeup_issue_queue_pkg::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int ENTRY_WIDTH = $clog2(NUM_ENTRIES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [AL_FUNC-1:0]      insn,
    input  logic [REG_ADDR_LEN-1:0] inp1,
    input  logic [REG_ADDR_LEN-1:0] inp2,
    input  logic                    inp1_ready,
    input  logic                    inp2_ready,
    input  logic [REG_ADDR_LEN-1:0] dst,
    input  logic                    cdb_valid,
    input  logic [REG_ADDR_LEN-1:0] cdb_tag,
    input  logic                    issue,
    output logic                    issue_ready,
    output logic                    is_full,
    output logic [ENTRY_WIDTH:0]    count,
    output logic [AL_FUNC-1:0]      insn_out,
    output logic [REG_ADDR_LEN-1:0] inp1_out,
    output logic [REG_ADDR_LEN-1:0] inp2_out,
    output logic [REG_ADDR_LEN-1:0] dst_out
);

    iq_entry_t                q      [NUM_ENTRIES];
    iq_entry_t                q_next [NUM_ENTRIES];
    iq_entry_t                woken  [NUM_ENTRIES];
    iq_entry_t                new_entry;
    logic [ENTRY_WIDTH:0]     count_next;
    logic [ENTRY_WIDTH:0]     load_slot;
    logic [NUM_ENTRIES-1:0]   req;
    logic [NUM_ENTRIES-1:0]   grant;
    logic [ENTRY_WIDTH-1:0]   sel_idx;
    logic                     sel_any;
    logic                     do_issue;
    logic                     do_load;

    assign is_full     = (count == (ENTRY_WIDTH+1)'(NUM_ENTRIES));
    assign issue_ready = sel_any;
    assign do_issue    = issue & sel_any;
    assign do_load     = load & ~is_full;

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            req[i] = q[i].valid & q[i].rdy1 & q[i].rdy2;
        end
    end

    iq_oldest_ready_select #(
        .N (NUM_ENTRIES),
        .W (ENTRY_WIDTH)
    ) u_select (
        .req   (req),
        .grant (grant),
        .idx   (sel_idx),
        .any   (sel_any)
    );

    // One-hot AND-OR mux: with no grant every output collapses to zero.
    always_comb begin
        insn_out = '0;
        inp1_out = '0;
        inp2_out = '0;
        dst_out  = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            insn_out = insn_out | ({AL_FUNC{grant[i]}}      & q[i].insn);
            inp1_out = inp1_out | ({REG_ADDR_LEN{grant[i]}} & q[i].inp1);
            inp2_out = inp2_out | ({REG_ADDR_LEN{grant[i]}} & q[i].inp2);
            dst_out  = dst_out  | ({REG_ADDR_LEN{grant[i]}} & q[i].dst);
        end
    end

    always_comb begin
        new_entry       = '0;
        new_entry.valid = 1'b1;
        new_entry.insn  = insn;
        new_entry.inp1  = inp1;
        new_entry.inp2  = inp2;
        new_entry.dst   = dst;
`ifdef IQ_LOAD_BYPASS_EN
        new_entry.rdy1  = inp1_ready | (cdb_valid & (cdb_tag == inp1));
        new_entry.rdy2  = inp2_ready | (cdb_valid & (cdb_tag == inp2));
`else
        new_entry.rdy1  = inp1_ready;
        new_entry.rdy2  = inp2_ready;
`endif
    end

    // Wakeup is applied before the collapse so a shifting entry carries its new ready bit down.
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            woken[i] = iq_wakeup(q[i], cdb_valid, cdb_tag);
        end

        for (int i = 0; i < NUM_ENTRIES - 1; i++) begin
            if (do_issue && (ENTRY_WIDTH'(i) >= sel_idx)) begin
                q_next[i] = woken[i+1];
            end else begin
                q_next[i] = woken[i];
            end
        end
        q_next[NUM_ENTRIES-1] = do_issue ? '0 : woken[NUM_ENTRIES-1];

        load_slot = do_issue ? (count - (ENTRY_WIDTH+1)'(1)) : count;
        if (do_load) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (load_slot == (ENTRY_WIDTH+1)'(i)) begin
                    q_next[i] = new_entry;
                end
            end
        end

        count_next = count;
        if (do_load && !do_issue) begin
            count_next = count + (ENTRY_WIDTH+1)'(1);
        end else if (do_issue && !do_load) begin
            count_next = count - (ENTRY_WIDTH+1)'(1);
        end
    end

    // NOTE: the entry array is cleared on reset because select reads valid/ready bits directly; stale bits would issue garbage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                q[i] <= '0;
            end
            count <= '0;
        end else begin
            q     <= q_next;
            count <= count_next;
        end
    end

endmodule

// File: tb/tb_wakeup_issue_queue.sv
// Directed self-checking bench for wakeup_issue_queue (default depth 4); expectations
// for the dispatch-bypass case follow IQ_LOAD_BYPASS_EN.
module tb_wakeup_issue_queue;
    import wakeup_issue_queue_pkg::*;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    load;
    logic [AL_FUNC-1:0]      insn;
    logic [REG_ADDR_LEN-1:0] inp1, inp2, dst;
    logic                    inp1_ready, inp2_ready;
    logic                    cdb_valid;
    logic [REG_ADDR_LEN-1:0] cdb_tag;
    logic                    issue;
    logic                    issue_ready;
    logic                    is_full;
    logic [2:0]              count;
    logic [AL_FUNC-1:0]      insn_out;
    logic [REG_ADDR_LEN-1:0] inp1_out, inp2_out, dst_out;

    int errors = 0;
    int checks = 0;

    wakeup_issue_queue #(.NUM_ENTRIES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .insn        (insn),
        .inp1        (inp1),
        .inp2        (inp2),
        .inp1_ready  (inp1_ready),
        .inp2_ready  (inp2_ready),
        .dst         (dst),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .issue       (issue),
        .issue_ready (issue_ready),
        .is_full     (is_full),
        .count       (count),
        .insn_out    (insn_out),
        .inp1_out    (inp1_out),
        .inp2_out    (inp2_out),
        .dst_out     (dst_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic idle();
        reset = 1'b0; load = 1'b0; issue = 1'b0; cdb_valid = 1'b0; cdb_tag = '0;
        insn = '0; inp1 = '0; inp2 = '0; dst = '0; inp1_ready = 1'b0; inp2_ready = 1'b0;
    endtask

    task automatic set_load(input alu_op_e op, input int a, input int b, input int d,
                            input logic ra, input logic rb);
        load = 1'b1; insn = op;
        inp1 = REG_ADDR_LEN'(a); inp2 = REG_ADDR_LEN'(b); dst = REG_ADDR_LEN'(d);
        inp1_ready = ra; inp2_ready = rb;
    endtask

    task automatic set_cdb(input int tag);
        cdb_valid = 1'b1; cdb_tag = REG_ADDR_LEN'(tag);
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled there too, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    logic bypass;

    initial begin
`ifdef IQ_LOAD_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif
        idle();
        #1;

        // 1: reset, then a ready ADD issues the cycle after dispatch
        reset = 1'b1;
        tick();
        check("rst_count", 32'(count), 0);
        check("rst_full", 32'(is_full), 0);
        check("rst_ready", 32'(issue_ready), 0);
        check("rst_insn", 32'(insn_out), 0);
        check("rst_dst", 32'(dst_out), 0);

        set_load(ALU_ADD, 1, 2, 3, 1'b1, 1'b1);
        tick();
        check("t1_count", 32'(count), 1);
        check("t1_ready", 32'(issue_ready), 1);
        check("t1_insn", 32'(insn_out), 32'(ALU_ADD));
        check("t1_inp1", 32'(inp1_out), 1);
        check("t1_inp2", 32'(inp2_out), 2);
        check("t1_dst", 32'(dst_out), 3);
        issue = 1'b1;
        tick();
        check("t1_iss_count", 32'(count), 0);
        check("t1_iss_ready", 32'(issue_ready), 0);
        check("t1_iss_insn", 32'(insn_out), 0);
        check("t1_iss_dst", 32'(dst_out), 0);

        // 2: younger ready AND overtakes older SUB waiting on tag 4
        set_load(ALU_SUB, 4, 5, 6, 1'b0, 1'b1);
        tick();
        set_load(ALU_AND, 8, 9, 10, 1'b1, 1'b1);
        tick();
        check("t2_count", 32'(count), 2);
        check("t2_insn", 32'(insn_out), 32'(ALU_AND));
        check("t2_dst", 32'(dst_out), 10);
        issue = 1'b1;
        tick();
        check("t2_after_and_count", 32'(count), 1);
        check("t2_sub_waiting", 32'(issue_ready), 0);
        set_cdb(4);
        tick();
        check("t2_sub_woken", 32'(issue_ready), 1);
        check("t2_sub_insn", 32'(insn_out), 32'(ALU_SUB));
        check("t2_sub_dst", 32'(dst_out), 6);
        issue = 1'b1;
        tick();
        check("t2_empty", 32'(count), 0);

        // 3: fill with unready ops; load while full is dropped, stray issue ignored
        set_load(ALU_OR, 30, 31, 1, 1'b0, 1'b0);  tick();
        set_load(ALU_XOR, 32, 33, 2, 1'b0, 1'b0); tick();
        set_load(ALU_SRA, 34, 35, 3, 1'b0, 1'b0); tick();
        set_load(ALU_SUB, 36, 37, 4, 1'b0, 1'b0); tick();
        check("t3_full", 32'(is_full), 1);
        check("t3_count", 32'(count), 4);
        check("t3_ready", 32'(issue_ready), 0);
        set_load(ALU_SLL, 40, 41, 5, 1'b1, 1'b1);
        tick();
        check("t3_drop_count", 32'(count), 4);
        check("t3_drop_ready", 32'(issue_ready), 0);
        issue = 1'b1;
        tick();
        check("t3_noissue_count", 32'(count), 4);

        // 4: slot 2 leaves; the load is dropped; wakeup on shifting slot 3 is kept
        set_cdb(34); tick();
        set_cdb(35); tick();
        check("t4_sra_ready", 32'(issue_ready), 1);
        check("t4_sra_insn", 32'(insn_out), 32'(ALU_SRA));
        check("t4_sra_dst", 32'(dst_out), 3);
        set_load(ALU_SLL, 40, 41, 5, 1'b1, 1'b1);
        issue = 1'b1;
        set_cdb(36);
        tick();
        check("t4_count", 32'(count), 3);
        check("t4_full", 32'(is_full), 0);
        check("t4_ready", 32'(issue_ready), 0);
        set_cdb(37);
        tick();
        check("t4_shifted_ready", 32'(issue_ready), 1);
        check("t4_shifted_insn", 32'(insn_out), 32'(ALU_SUB));
        check("t4_shifted_dst", 32'(dst_out), 4);
        issue = 1'b1;
        tick();
        check("t4_after_count", 32'(count), 2);
        check("t4_after_ready", 32'(issue_ready), 0);

        // 5: load + issue + wakeup in one cycle; count holds at 2, new XOR ends up ready
        set_cdb(32); tick();
        set_cdb(33); tick();
        check("t5_xor2_insn", 32'(insn_out), 32'(ALU_XOR));
        check("t5_xor2_dst", 32'(dst_out), 2);
        // Without the bypass, dispatch folds the same-cycle broadcast into inp1_ready itself.
        set_load(ALU_XOR, 12, 13, 14, ~bypass, 1'b1);
        issue = 1'b1;
        set_cdb(12);
        tick();
        check("t5_count", 32'(count), 2);
        check("t5_ready", 32'(issue_ready), 1);
        check("t5_insn", 32'(insn_out), 32'(ALU_XOR));
        check("t5_dst", 32'(dst_out), 14);
        check("t5_inp1", 32'(inp1_out), 12);
        issue = 1'b1;
        tick();
        check("t5_after_count", 32'(count), 1);

        // 6: dispatch-time CDB bypass, then a mid-run reset drops everything
        set_load(ALU_SRL, 19, 20, 21, 1'b0, 1'b0);
        set_cdb(19);
        tick();
        check("t6_count", 32'(count), 2);
        check("t6_ready0", 32'(issue_ready), 0);
        set_cdb(20);
        tick();
        check("t6_bypass_ready", 32'(issue_ready), 32'(bypass));
        check("t6_bypass_dst", 32'(dst_out), bypass ? 32'd21 : 32'd0);
        reset = 1'b1;
        set_load(ALU_ADD, 1, 2, 3, 1'b1, 1'b1);
        tick();
        check("t6_rst_count", 32'(count), 0);
        check("t6_rst_ready", 32'(issue_ready), 0);
        check("t6_rst_full", 32'(is_full), 0);
        check("t6_rst_insn", 32'(insn_out), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
